// File: rtl/serial_frame_gen_if.sv
// Handshake and serial-output bundle for serial_frame_gen.
// When SERIAL_FRAME_GEN_LOOP_EN is defined, the bundle also carries the `loop` control.
interface serial_frame_gen_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] pdata;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

`ifdef SERIAL_FRAME_GEN_LOOP_EN
  logic             loop;

  modport master (
    output load_valid, pdata, loop,
    input  load_ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  load_valid, pdata, loop,
    output load_ready, sout, sout_valid, busy, done
  );
`else
  modport master (
    output load_valid, pdata,
    input  load_ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  load_valid, pdata,
    output load_ready, sout, sout_valid, busy, done
  );
`endif
endinterface

// File: rtl/serial_frame_gen.sv
// Parallel-to-serial frame source feeding the sequence detector's din, with gapless back-to-back frames.
// Optional macro SERIAL_FRAME_GEN_LOOP_EN adds a `loop` input that repeats the last accepted word.
module serial_frame_gen #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               clr,
  serial_frame_gen_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [CW-1:0] CNT_FIRST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             sout_q;
  logic             sout_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             load_ready;
  logic             accept;
  logic             reload;
  logic [WIDTH-1:0] reload_word;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] tail(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Ready while idle or while the final bit of the current frame is on sout.
  assign load_ready = (state == IDLE) || (cnt == '0);
  assign accept     = bus.load_valid && load_ready;

`ifdef SERIAL_FRAME_GEN_LOOP_EN
  logic [WIDTH-1:0] held;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      held <= '0;
    end else if (accept) begin
      held <= bus.pdata;
    end
  end
`endif

  // A fresh frame always wins; looping only fills an otherwise idle last-bit slot.
  always_comb begin
    reload      = accept;
    reload_word = bus.pdata;
`ifdef SERIAL_FRAME_GEN_LOOP_EN
    if (!accept && state == SHIFT && cnt == '0 && bus.loop) begin
      reload      = 1'b1;
      reload_word = held;
    end
`endif
  end

  // shreg holds only the bits still to be shown; sout_q is the bit currently on the line.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state        <= IDLE;
      shreg        <= '0;
      cnt          <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (reload) begin
      state        <= SHIFT;
      shreg        <= tail(reload_word);
      sout_q       <= head(reload_word);
      cnt          <= CNT_FIRST;
      sout_valid_q <= 1'b1;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
    end else if (state == SHIFT && cnt != '0) begin
      shreg        <= tail(shreg);
      sout_q       <= head(shreg);
      cnt          <= cnt - CNT_ONE;
      sout_valid_q <= 1'b1;
      busy_q       <= 1'b1;
      done_q       <= (cnt == CNT_ONE);
    end else begin
      state        <= IDLE;
      shreg        <= '0;
      cnt          <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = sout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  a_quiet_line: assert property (@(posedge clk) disable iff (clr) !sout_valid_q |-> !sout_q);
  a_done_in_frame: assert property (@(posedge clk) disable iff (clr) done_q |-> sout_valid_q);
endmodule

// File: tb/tb_serial_frame_gen.sv
// Randomized scoreboard bench for serial_frame_gen across four width/bit-order lanes.
module tb_serial_frame_gen;
  logic        clk;
  logic        clr;
  logic        lv;
  logic [31:0] pd;

  int vectors;
  int errors;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input int lane_id, input string name,
                             input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL lane%0d %s at %0t: got %0h, want %0h", lane_id, name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic c);
    @(posedge clk);
    #1;
    lv  = v;
    pd  = d;
    clr = c;
  endtask

  // Each lane gets the same upstream drive; the reference model decides independently when it accepts.
  for (genvar g = 0; g < 4; g++) begin : lane
    localparam int W = (g == 0) ? 8 : (g == 1) ? 8 : (g == 2) ? 5 : 2;
    localparam bit M = (g == 0) || (g == 2);

    serial_frame_gen_if #(.WIDTH(W)) bus ();

    serial_frame_gen #(.WIDTH(W), .MSB_FIRST(M)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus.slave)
    );

    assign bus.load_valid = lv;
    assign bus.pdata      = pd[W-1:0];
`ifdef SERIAL_FRAME_GEN_LOOP_EN
    assign bus.loop       = 1'b0;
`endif

    exp_t q[$];
    exp_t e;
    logic m_ready = 1'b1;

    always @(posedge clk) begin
      if (!clr && lv && m_ready) begin
        for (int i = 0; i < W; i++) begin
          q.push_back('{b: (M ? pd[W-1-i] : pd[i]), last: (i == W - 1)});
        end
      end
    end

    always @(negedge clk) begin
      if (clr) begin
        q.delete();
        m_ready = 1'b1;
        checkOutput(g, "reset_outputs", {28'd0, bus.sout, bus.sout_valid, bus.busy, bus.done}, 32'd0);
        checkOutput(g, "reset_load_ready", {31'd0, bus.load_ready}, 32'd1);
      end else begin
        if (q.size() > 0) begin
          e = q.pop_front();
          checkOutput(g, "sout_valid", {31'd0, bus.sout_valid}, 32'd1);
          checkOutput(g, "sout", {31'd0, bus.sout}, {31'd0, e.b});
          checkOutput(g, "done", {31'd0, bus.done}, {31'd0, e.last});
          checkOutput(g, "busy", {31'd0, bus.busy}, 32'd1);
        end else begin
          checkOutput(g, "idle_outputs", {28'd0, bus.sout, bus.sout_valid, bus.busy, bus.done}, 32'd0);
        end
        m_ready = (q.size() == 0);
        checkOutput(g, "load_ready", {31'd0, bus.load_ready}, {31'd0, m_ready});
      end
    end
  end

  initial begin
    vectors = 0;
    errors  = 0;
    clr = 1'b1;
    lv  = 1'b0;
    pd  = '0;

    repeat (5) applyStimulus(1'b0, 32'h0, 1'b1);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b0);

    $display("[TB] single frame");
    applyStimulus(1'b1, 32'h11, 1'b0);
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b0);

    $display("[TB] back-to-back frames");
    repeat (8) applyStimulus(1'b1, 32'hA5, 1'b0);
    repeat (8) applyStimulus(1'b1, 32'h3C, 1'b0);
    repeat (20) applyStimulus(1'b0, 32'h0, 1'b0);

    $display("[TB] low-bit frame");
    applyStimulus(1'b1, 32'h01, 1'b0);
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b0);

    $display("[TB] mid-frame abort");
    applyStimulus(1'b1, 32'hFF, 1'b0);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h81, 1'b0);
    repeat (12) applyStimulus(1'b0, 32'h0, 1'b0);

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 199) == 0);
    end
    repeat (20) applyStimulus(1'b0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
